// File: rtl/dmem_pkg.sv
// Shared widths and enumerations for the data-memory arbiter.
package dmem_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int BE_W   = 2;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      P0   = 2'd1,
      P1   = 2'd2
   } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports and memory port bundled for the arbiter; slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if;
   import dmem_pkg::*;

   logic              p0_req;
   logic [BE_W-1:0]   p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_gnt;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_rvalid;

   logic              p1_req;
   logic [BE_W-1:0]   p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_lock;
   logic              p1_gnt;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_rvalid;

   logic [ADDR_W-1:0] dread_addr;
   logic [DATA_W-1:0] dread_data;
   logic [ADDR_W-1:0] dwrite_addr;
   logic [DATA_W-1:0] dwrite_data;
   logic [BE_W-1:0]   dwrite_en;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_gnt, p0_rdata, p0_rvalid,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
      output p1_gnt, p1_rdata, p1_rvalid,
      output dread_addr, dwrite_addr, dwrite_data, dwrite_en,
      input  dread_data
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_gnt, p0_rdata, p0_rvalid,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
      input  p1_gnt, p1_rdata, p1_rvalid,
      input  dread_addr, dwrite_addr, dwrite_data, dwrite_en,
      output dread_data
   );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: fixed priority for the cpu, wait boost and burst lock
// for the external master, and routing of 1-cycle read returns to the issuing port.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_WAIT = 4,
   parameter int LOCK_MAX = 8
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int LOCK_W = $clog2(LOCK_MAX + 1);

   arb_state_t        r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [LOCK_W-1:0] r_lock_cnt;
   owner_t            r_owner;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;

   logic              w_boost;
   logic              w_arb_gnt0;
   logic              w_arb_gnt1;
   logic              w_lock_hold;
   logic              w_lock_yield;
   logic              w_gnt0;
   logic              w_gnt1;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [BE_W-1:0]   w_we;
   logic [DATA_W-1:0] w_p0_rdata;
   logic [DATA_W-1:0] w_p1_rdata;

   // A held lock bypasses normal arbitration except for the periodic cpu yield slot.
   always_comb begin
      w_boost      = (r_wait_cnt == WAIT_W'(MAX_WAIT));
      w_arb_gnt1   = bus.p1_req && (w_boost || !bus.p0_req);
      w_arb_gnt0   = bus.p0_req && !(w_boost && bus.p1_req);
      w_lock_hold  = (r_state == LOCKED) && bus.p1_req && bus.p1_lock;
      w_lock_yield = w_lock_hold && (r_lock_cnt == LOCK_W'(LOCK_MAX)) && bus.p0_req;
      w_gnt0       = reset && (w_lock_hold ? w_lock_yield  : w_arb_gnt0);
      w_gnt1       = reset && (w_lock_hold ? !w_lock_yield : w_arb_gnt1);
   end

   always_comb begin
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_we    = '0;
      if (w_gnt1) begin
         w_addr  = bus.p1_addr;
         w_wdata = bus.p1_wdata;
         w_we    = bus.p1_we;
      end else if (w_gnt0) begin
         w_addr  = bus.p0_addr;
         w_wdata = bus.p0_wdata;
         w_we    = bus.p0_we;
      end
   end

   always_comb begin
      w_p0_rdata = (r_owner == P0) ? bus.dread_data : r_p0_rdata;
      w_p1_rdata = (r_owner == P1) ? bus.dread_data : r_p1_rdata;
      if (!reset) begin
         w_p0_rdata = '0;
         w_p1_rdata = '0;
      end
   end

   assign bus.p0_gnt      = w_gnt0;
   assign bus.p1_gnt      = w_gnt1;
   assign bus.dread_addr  = w_addr;
   assign bus.dwrite_addr = w_addr;
   assign bus.dwrite_data = w_wdata;
   assign bus.dwrite_en   = w_we;
   assign bus.p0_rdata    = w_p0_rdata;
   assign bus.p1_rdata    = w_p1_rdata;
   // Gating with reset kills a return whose read was granted just before reset.
   assign bus.p0_rvalid   = reset && (r_owner == P0);
   assign bus.p1_rvalid   = reset && (r_owner == P1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= ARB;
         r_wait_cnt <= '0;
         r_lock_cnt <= '0;
         r_owner    <= NONE;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
      end else begin
         if (w_lock_hold) begin
            r_state <= LOCKED;
            if (w_lock_yield)
               r_lock_cnt <= '0;
            else if (r_lock_cnt != LOCK_W'(LOCK_MAX))
               r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
         end else if (w_gnt1 && bus.p1_lock) begin
            r_state    <= LOCKED;
            r_lock_cnt <= LOCK_W'(1);
         end else begin
            r_state    <= ARB;
            r_lock_cnt <= '0;
         end

         if (bus.p1_req && !w_gnt1) begin
            if (!w_boost)
               r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end else begin
            r_wait_cnt <= '0;
         end

         if (w_gnt0 && (bus.p0_we == '0))
            r_owner <= P0;
         else if (w_gnt1 && (bus.p1_we == '0))
            r_owner <= P1;
         else
            r_owner <= NONE;

         r_p0_rdata <= w_p0_rdata;
         r_p1_rdata <= w_p1_rdata;
      end
   end

   // Memory address/data hold their last granted value while idle.
   always_ff @(posedge clk) begin
      if (w_gnt0 || w_gnt1) begin
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural arbitration and memory model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int MAX_WAIT = 4;
   localparam int LOCK_MAX = 8;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } sb_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   dmem_arbiter_if bus ();

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // memory: one-cycle read latency, byte-enabled writes
   logic [15:0] mem [0:255];
   logic [15:0] ref_mem [0:255];
   always @(posedge clk) begin
      if (bus.dwrite_en[0]) mem[bus.dwrite_addr[8:1]][7:0]  <= bus.dwrite_data[7:0];
      if (bus.dwrite_en[1]) mem[bus.dwrite_addr[8:1]][15:8] <= bus.dwrite_data[15:8];
      bus.dread_data <= mem[bus.dread_addr[8:1]];
   end

   sb_t         sbq [2][$];
   logic [15:0] last_rd [2];

   // reference model state
   int          m_wait = 0;
   bit          m_locked = 0;
   int          m_run = 0;
   bit          m_addr_known = 0;
   logic [15:0] m_addr = '0;
   bit          obs_g0, obs_g1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic mon_port(input int p, input logic rv, input logic [15:0] rd);
      sb_t e;
      if (!reset) begin
         chk($sformatf("rvalid_in_reset_p%0d", p), {31'd0, rv}, 32'd0);
         chk($sformatf("rdata_in_reset_p%0d", p), {16'd0, rd}, 32'd0);
         last_rd[p] = '0;
      end else if (rv) begin
         if (sbq[p].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid_p%0d at cycle %0d: got rvalid 1 expected 0", p, cyc);
         end else begin
            e = sbq[p].pop_front();
            chk($sformatf("rvalid_latency_p%0d", p), cyc, e.cyc + 1);
            chk($sformatf("rdata_p%0d", p), {16'd0, rd}, {16'd0, e.data});
            last_rd[p] = e.data;
         end
      end else begin
         chk($sformatf("rdata_hold_p%0d", p), {16'd0, rd}, {16'd0, last_rd[p]});
         if (sbq[p].size() > 0 && sbq[p][0].cyc + 1 <= cyc) begin
            e = sbq[p].pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rvalid_p%0d at cycle %0d: got rvalid 0 expected 1", p, cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      mon_port(0, bus.p0_rvalid, bus.p0_rdata);
      mon_port(1, bus.p1_rvalid, bus.p1_rdata);
   end

   task automatic step(input logic rn,
                       input logic r0, input logic [1:0] w0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic [1:0] w1, input logic [15:0] a1, input logic [15:0] d1,
                       input logic l1);
      bit          e0, e1, in_burst;
      logic [1:0]  we;
      logic [15:0] ad, wd;
      sb_t         ent;
      @(posedge clk);
      #1;
      reset        = rn;
      bus.p0_req   = r0;  bus.p0_we = w0;  bus.p0_addr = a0;  bus.p0_wdata = d0;
      bus.p1_req   = r1;  bus.p1_we = w1;  bus.p1_addr = a1;  bus.p1_wdata = d1;
      bus.p1_lock  = l1;
      if (!rn) begin
         sbq[0].delete();
         sbq[1].delete();
      end
      @(negedge clk);
      obs_g0 = bus.p0_gnt;
      obs_g1 = bus.p1_gnt;

      e0 = 0;
      e1 = 0;
      in_burst = m_locked && r1 && l1;
      if (rn) begin
         if (in_burst) begin
            if (m_run >= LOCK_MAX && r0) e0 = 1;
            else e1 = 1;
         end else if (r1 && (m_wait >= MAX_WAIT || !r0)) e1 = 1;
         else if (r0) e0 = 1;
      end

      chk("p0_gnt", {31'd0, bus.p0_gnt}, {31'd0, e0});
      chk("p1_gnt", {31'd0, bus.p1_gnt}, {31'd0, e1});
      if (e0 || e1) begin
         we = e1 ? w1 : w0;
         ad = e1 ? a1 : a0;
         wd = e1 ? d1 : d0;
         chk("dwrite_en", {30'd0, bus.dwrite_en}, {30'd0, we});
         chk("dread_addr", {16'd0, bus.dread_addr}, {16'd0, ad});
         chk("dwrite_addr", {16'd0, bus.dwrite_addr}, {16'd0, ad});
         if (we != 2'b00) begin
            chk("dwrite_data", {16'd0, bus.dwrite_data}, {16'd0, wd});
            if (we[0]) ref_mem[ad[8:1]][7:0]  = wd[7:0];
            if (we[1]) ref_mem[ad[8:1]][15:8] = wd[15:8];
         end else begin
            ent.cyc  = cyc;
            ent.data = ref_mem[ad[8:1]];
            sbq[e1 ? 1 : 0].push_back(ent);
         end
         m_addr = ad;
         m_addr_known = 1;
      end else begin
         chk("dwrite_en_idle", {30'd0, bus.dwrite_en}, 32'd0);
         if (m_addr_known && rn)
            chk("dread_addr_hold", {16'd0, bus.dread_addr}, {16'd0, m_addr});
      end

      if (!rn) begin
         m_wait = 0;
         m_locked = 0;
         m_run = 0;
      end else begin
         if (in_burst) begin
            if (e0) m_run = 0;
            else if (m_run < LOCK_MAX) m_run++;
         end else if (e1 && l1) begin
            m_locked = 1;
            m_run = 1;
         end else begin
            m_locked = 0;
            m_run = 0;
         end
         if (r1 && !e1) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
         else m_wait = 0;
      end
   endtask

   function automatic logic [15:0] raddr();
      return 16'($urandom_range(0, 255) * 2);
   endfunction

   initial begin
      int n1, n0_after, guard, n0_run;
      logic [1:0] rw0, rw1;
      last_rd[0] = '0;
      last_rd[1] = '0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[8'h08]     = 16'h1234;
      ref_mem[8'h08] = 16'h1234;
      bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
      bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0; bus.p1_lock = 0;

      // reset with both requesting, then p0 must win the first free cycle
      step(0, 1, 0, 16'h0000, 0, 1, 0, 16'h0002, 0, 0);
      step(0, 1, 0, 16'h0000, 0, 1, 0, 16'h0002, 0, 0);
      step(1, 1, 0, 16'h0000, 0, 1, 0, 16'h0002, 0, 0);
      chk("first_gnt_after_reset", {31'd0, obs_g0}, 32'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // directed cpu read of 0x0010
      step(1, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // continuous contention: p0 x MAX_WAIT, then p1
      n0_run = 0;
      for (int i = 0; i < 15; i++) begin
         step(1, 1, 0, raddr(), 0, 1, 0, raddr(), 0, 0);
         if (obs_g0) n0_run++;
      end
      chk("contention_p0_share", n0_run, 12);

      // p1 low-byte write
      step(1, 0, 0, 0, 0, 1, 2'b01, 16'h0020, 16'hABCD, 0);
      step(1, 1, 0, 16'h0020, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // locked burst of 12 with cpu contending throughout
      n1 = 0;
      n0_after = 0;
      guard = 0;
      while (n1 < 12 && guard < 60) begin
         step(1, 1, 0, raddr(), 0, 1, 0, raddr(), 0, 1);
         if (obs_g1) n1++;
         else if (obs_g0 && n1 > 0) n0_after++;
         guard++;
      end
      chk("burst_completed", n1, 12);
      chk("burst_cpu_yield", n0_after, 1);
      step(1, 1, 0, raddr(), 0, 0, 0, 0, 0, 0);

      // alternating back-to-back reads
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) step(1, 1, 0, 16'h0002, 0, 0, 0, 0, 0, 0);
         else            step(1, 0, 0, 0, 0, 1, 0, 16'h0004, 0, 0);
      end

      // read granted right before reset must never return
      step(1, 1, 0, 16'h0010, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rw0 = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rw1 = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         step(($urandom_range(0, 99) != 0),
              1'($urandom_range(0, 1)), rw0, raddr(), 16'($urandom),
              1'($urandom_range(0, 1)), rw1, raddr(), 16'($urandom),
              ($urandom_range(0, 2) != 0));
      end

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("sb_drained_p0", sbq[0].size(), 0);
      chk("sb_drained_p1", sbq[1].size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout at cycle %0d: got no finish expected finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
